// File: rtl/mem_arbiter_pkg.sv
// Shared types and constants for the CPU/DMA memory arbiter.
// Holds the arbiter state and owner enums, the beat-counter width and the tie-break helper.
package mem_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    OWN_CPU = 2'd1,
    OWN_DMA = 2'd2
  } arb_state_t;

  typedef enum logic {
    OWNER_CPU = 1'b0,
    OWNER_DMA = 1'b1
  } owner_t;

  localparam int BURST_CNT_W = 8;

  // On a tie, the requester that did not own the bus last time wins.
  function automatic owner_t tie_winner(input owner_t last);
    return (last == OWNER_CPU) ? OWNER_DMA : OWNER_CPU;
  endfunction

endpackage

// File: rtl/mem_arbiter.sv
// Round-robin arbiter granting one memory port to a CPU or DMA requester in bounded bursts.
// Optional feature: define MEM_ARBITER_STATS_EN to add stat_cpu_beats / stat_dma_beats outputs.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int MAX_BURST = 8
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_gnt,
  output logic              cpu_rvalid,
  output logic [DATA_W-1:0] cpu_rdata,
  input  logic              dma_req,
  input  logic              dma_we,
  input  logic [ADDR_W-1:0] dma_addr,
  input  logic [DATA_W-1:0] dma_wdata,
  output logic              dma_gnt,
  output logic              dma_rvalid,
  output logic [DATA_W-1:0] dma_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
`ifdef MEM_ARBITER_STATS_EN
  ,
  output logic [31:0]       stat_cpu_beats,
  output logic [31:0]       stat_dma_beats
`endif
);

  localparam logic [BURST_CNT_W-1:0] LAST_BEAT = BURST_CNT_W'(MAX_BURST - 1);

  arb_state_t             state;
  owner_t                 last_owner;
  logic [BURST_CNT_W-1:0] beat_cnt;
  logic                   cpu_tag;
  logic                   dma_tag;
  logic                   cpu_beat;
  logic                   dma_beat;
  logic                   cpu_release;
  logic                   dma_release;

  // Grants come from the state register alone; reset forces every output low.
  assign cpu_gnt  = (state == OWN_CPU) && !reset;
  assign dma_gnt  = (state == OWN_DMA) && !reset;
  assign cpu_beat = cpu_req && cpu_gnt;
  assign dma_beat = dma_req && dma_gnt;

  assign cpu_release = !cpu_req || (beat_cnt == LAST_BEAT);
  assign dma_release = !dma_req || (beat_cnt == LAST_BEAT);

  always_comb begin
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (cpu_beat) begin
      mem_en    = 1'b1;
      mem_we    = cpu_we;
      mem_addr  = cpu_addr;
      mem_wdata = cpu_wdata;
    end else if (dma_beat) begin
      mem_en    = 1'b1;
      mem_we    = dma_we;
      mem_addr  = dma_addr;
      mem_wdata = dma_wdata;
    end
  end

  // The tags remember who issued last cycle's read so the returning data can be routed.
  assign cpu_rvalid = cpu_tag && !reset;
  assign dma_rvalid = dma_tag && !reset;
  assign cpu_rdata  = cpu_rvalid ? mem_rdata : '0;
  assign dma_rdata  = dma_rvalid ? mem_rdata : '0;

  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= IDLE;
      last_owner <= OWNER_DMA;
      beat_cnt   <= '0;
      cpu_tag    <= 1'b0;
      dma_tag    <= 1'b0;
    end else begin
      cpu_tag <= cpu_beat && !cpu_we;
      dma_tag <= dma_beat && !dma_we;
      case (state)
        IDLE: begin
          beat_cnt <= '0;
          if (cpu_req && dma_req) begin
            state <= (tie_winner(last_owner) == OWNER_CPU) ? OWN_CPU : OWN_DMA;
          end else if (cpu_req) begin
            state <= OWN_CPU;
          end else if (dma_req) begin
            state <= OWN_DMA;
          end
        end
        OWN_CPU: begin
          if (cpu_release) begin
            last_owner <= OWNER_CPU;
            beat_cnt   <= '0;
            state      <= dma_req ? OWN_DMA : IDLE;
          end else begin
            beat_cnt <= beat_cnt + 1'b1;
          end
        end
        OWN_DMA: begin
          if (dma_release) begin
            last_owner <= OWNER_DMA;
            beat_cnt   <= '0;
            state      <= cpu_req ? OWN_CPU : IDLE;
          end else begin
            beat_cnt <= beat_cnt + 1'b1;
          end
        end
        default: begin
          state    <= IDLE;
          beat_cnt <= '0;
        end
      endcase
    end
  end

`ifdef MEM_ARBITER_STATS_EN
  logic [31:0] cpu_beats_q;
  logic [31:0] dma_beats_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      cpu_beats_q <= '0;
      dma_beats_q <= '0;
    end else begin
      if (cpu_beat) cpu_beats_q <= cpu_beats_q + 32'd1;
      if (dma_beat) dma_beats_q <= dma_beats_q + 32'd1;
    end
  end

  assign stat_cpu_beats = reset ? 32'd0 : cpu_beats_q;
  assign stat_dma_beats = reset ? 32'd0 : dma_beats_q;
`endif

  a_one_grant : assert property (@(posedge clock) !(cpu_gnt && dma_gnt));
  a_one_rvalid : assert property (@(posedge clock) !(cpu_rvalid && dma_rvalid));

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: a cycle-level ownership model is compared on every negedge,
// and hand-computed literals pin the key scenarios.
module tb_mem_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int MB = 8;

  logic          clock = 1'b0;
  logic          reset;
  logic          cpu_req, cpu_we, cpu_gnt, cpu_rvalid;
  logic [AW-1:0] cpu_addr;
  logic [DW-1:0] cpu_wdata, cpu_rdata;
  logic          dma_req, dma_we, dma_gnt, dma_rvalid;
  logic [AW-1:0] dma_addr;
  logic [DW-1:0] dma_wdata, dma_rdata;
  logic          mem_en, mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, mem_rdata;
`ifdef MEM_ARBITER_STATS_EN
  logic [31:0]   stat_cpu_beats, stat_dma_beats;
`endif

  int checks = 0;
  int errors = 0;

  // Model state: owner 0=none 1=cpu 2=dma
  int          m_owner = 0;
  int          m_last  = 2;
  int          m_cnt   = 0;
  bit          pend_valid = 1'b0;
  int          pend_who = 0;
  logic [31:0] pend_addr = '0;
  logic [31:0] m_stat_c = '0;
  logic [31:0] m_stat_d = '0;

  always #5 clock = ~clock;

  mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_BURST(MB)) dut (
    .clock(clock), .reset(reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
    .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
    .dma_gnt(dma_gnt), .dma_rvalid(dma_rvalid), .dma_rdata(dma_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
`ifdef MEM_ARBITER_STATS_EN
    ,
    .stat_cpu_beats(stat_cpu_beats), .stat_dma_beats(stat_dma_beats)
`endif
  );

  function automatic logic [31:0] mem_func(input logic [31:0] a);
    if (a == 32'h20) return 32'hDEADBEEF;
    return {~a[15:0], a[15:0]};
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Compare DUT against the model, then advance the model to the next cycle.
  always @(negedge clock) begin : compare
    logic e_cg, e_dg, b_c, b_d, e_en, e_we, e_crv, e_drv, own_req, other_req;
    logic [31:0] e_addr, e_wdata, e_crd, e_drd;
    e_cg    = !reset && (m_owner == 1);
    e_dg    = !reset && (m_owner == 2);
    b_c     = e_cg && cpu_req;
    b_d     = e_dg && dma_req;
    e_en    = b_c || b_d;
    e_we    = b_c ? cpu_we : (b_d ? dma_we : 1'b0);
    e_addr  = b_c ? cpu_addr : (b_d ? dma_addr : 32'h0);
    e_wdata = b_c ? cpu_wdata : (b_d ? dma_wdata : 32'h0);
    e_crv   = !reset && pend_valid && (pend_who == 1);
    e_drv   = !reset && pend_valid && (pend_who == 2);
    e_crd   = e_crv ? mem_func(pend_addr) : 32'h0;
    e_drd   = e_drv ? mem_func(pend_addr) : 32'h0;

    check("cpu_gnt", 32'(cpu_gnt), 32'(e_cg));
    check("dma_gnt", 32'(dma_gnt), 32'(e_dg));
    check("mem_en", 32'(mem_en), 32'(e_en));
    check("mem_we", 32'(mem_we), 32'(e_we));
    check("mem_addr", mem_addr, e_addr);
    check("mem_wdata", mem_wdata, e_wdata);
    check("cpu_rvalid", 32'(cpu_rvalid), 32'(e_crv));
    check("dma_rvalid", 32'(dma_rvalid), 32'(e_drv));
    check("cpu_rdata", cpu_rdata, e_crd);
    check("dma_rdata", dma_rdata, e_drd);
`ifdef MEM_ARBITER_STATS_EN
    check("stat_cpu_beats", stat_cpu_beats, reset ? 32'h0 : m_stat_c);
    check("stat_dma_beats", stat_dma_beats, reset ? 32'h0 : m_stat_d);
`endif

    if (reset) begin
      m_owner = 0; m_last = 2; m_cnt = 0; pend_valid = 1'b0;
      m_stat_c = '0; m_stat_d = '0;
    end else begin
      pend_valid = e_en && !e_we;
      pend_who   = b_c ? 1 : 2;
      pend_addr  = e_addr;
      m_stat_c   = m_stat_c + 32'(b_c);
      m_stat_d   = m_stat_d + 32'(b_d);
      if (m_owner == 0) begin
        if (cpu_req && dma_req) m_owner = (m_last == 1) ? 2 : 1;
        else if (cpu_req)       m_owner = 1;
        else if (dma_req)       m_owner = 2;
        m_cnt = 0;
      end else begin
        own_req   = (m_owner == 1) ? cpu_req : dma_req;
        other_req = (m_owner == 1) ? dma_req : cpu_req;
        if (own_req) m_cnt++;
        if (!own_req || m_cnt == MB) begin
          m_last  = m_owner;
          m_owner = other_req ? 3 - m_owner : 0;
          m_cnt   = 0;
        end
      end
    end
  end

  task automatic settle;
    @(negedge clock); #1;
  endtask

  task automatic advance;
    @(posedge clock); #1;
    mem_rdata = pend_valid ? mem_func(pend_addr) : $urandom();
  endtask

  task automatic set_cpu(input logic r, input logic w, input logic [31:0] a, input logic [31:0] d);
    cpu_req = r; cpu_we = w; cpu_addr = a; cpu_wdata = d;
  endtask

  task automatic set_dma(input logic r, input logic w, input logic [31:0] a, input logic [31:0] d);
    dma_req = r; dma_we = w; dma_addr = a; dma_wdata = d;
  endtask

  task automatic do_reset(input int n);
    reset = 1'b1;
    set_cpu(0, 0, 0, 0);
    set_dma(0, 0, 0, 0);
    repeat (n) begin
      settle;
      check("rst_cpu_gnt", 32'(cpu_gnt), 32'h0);
      check("rst_mem_en", 32'(mem_en), 32'h0);
      advance;
    end
    reset = 1'b0;
  endtask

  task automatic idle_cycles(input int n);
    set_cpu(0, 0, 0, 0);
    set_dma(0, 0, 0, 0);
    repeat (n) begin settle; advance; end
  endtask

  initial begin : watchdog
    #100000;
    $display("[TB] FAIL watchdog: simulation did not complete in time");
    $fatal(1, "[TB] timeout");
  end

  initial begin : stimulus
    int dma_beats, cpu_seen, first_run, c_cnt, d_cnt;
    bit saw_cpu;
    mem_rdata = '0;

    // Single CPU write right after reset
    do_reset(3);
    set_cpu(1, 1, 32'h10, 32'hA5);
    settle;
    check("a_c0_cpu_gnt", 32'(cpu_gnt), 32'h0);
    check("a_c0_mem_en", 32'(mem_en), 32'h0);
    advance;
    settle;
    check("a_c1_cpu_gnt", 32'(cpu_gnt), 32'h1);
    check("a_c1_mem_en", 32'(mem_en), 32'h1);
    check("a_c1_mem_we", 32'(mem_we), 32'h1);
    check("a_c1_mem_addr", mem_addr, 32'h10);
    check("a_c1_mem_wdata", mem_wdata, 32'hA5);
    advance;
    idle_cycles(2);

    // Tie after reset goes to the CPU; CPU drops after 2 beats, DMA takes over at once
    do_reset(2);
    set_cpu(1, 1, 32'h50, 32'h33);
    set_dma(1, 1, 32'h40, 32'h77);
    settle; advance;
    settle;
    check("b_c1_cpu_gnt", 32'(cpu_gnt), 32'h1);
    check("b_c1_dma_gnt", 32'(dma_gnt), 32'h0);
    advance;
    settle; advance;
    cpu_req = 1'b0;
    settle;
    check("b_c3_mem_en", 32'(mem_en), 32'h0);
    advance;
    settle;
    check("b_c4_dma_gnt", 32'(dma_gnt), 32'h1);
    check("b_c4_mem_addr", mem_addr, 32'h40);
    advance;
    idle_cycles(2);

    // DMA streams 20 reads with the CPU competing; bursts are capped at MB beats
    dma_beats = 0; cpu_seen = 0; first_run = -1; saw_cpu = 1'b0;
    for (int k = 0; k < 60 && dma_beats < 20; k++) begin
      set_cpu((k >= 1 && k <= 11), 0, 32'h200 + 32'(k), 0);
      set_dma(1, 0, 32'h100 + 32'(dma_beats), 0);
      settle;
      if (cpu_gnt && !saw_cpu) begin saw_cpu = 1'b1; first_run = dma_beats; end
      if (cpu_gnt && mem_en) cpu_seen++;
      if (dma_gnt && mem_en) dma_beats++;
      advance;
    end
    check("c_dma_total", 32'(dma_beats), 32'd20);
    check("c_dma_first_run", 32'(first_run), 32'd8);
    check("c_cpu_beats", 32'(cpu_seen), 32'd3);
    idle_cycles(3);

    // CPU read with data returning one cycle later
    set_cpu(1, 0, 32'h20, 0);
    settle; advance;
    settle;
    check("d_c1_cpu_rvalid", 32'(cpu_rvalid), 32'h0);
    advance;
    cpu_req = 1'b0;
    settle;
    check("d_c2_cpu_rvalid", 32'(cpu_rvalid), 32'h1);
    check("d_c2_cpu_rdata", cpu_rdata, 32'hDEADBEEF);
    check("d_c2_dma_rvalid", 32'(dma_rvalid), 32'h0);
    check("d_c2_dma_rdata", dma_rdata, 32'h0);
    advance;
    idle_cycles(2);

    // Reset right after a DMA read beat discards the pending read
    set_dma(1, 0, 32'h30, 0);
    settle; advance;
    settle;
    check("e_c1_dma_gnt", 32'(dma_gnt), 32'h1);
    check("e_c1_mem_addr", mem_addr, 32'h30);
    advance;
    reset = 1'b1;
    settle;
    check("e_c2_dma_rvalid", 32'(dma_rvalid), 32'h0);
    check("e_c2_dma_rdata", dma_rdata, 32'h0);
    advance;
    reset = 1'b0;
    settle;
    check("e_c3_dma_gnt", 32'(dma_gnt), 32'h0);
    check("e_c3_dma_rvalid", 32'(dma_rvalid), 32'h0);
    advance;
    settle;
    check("e_c4_dma_gnt", 32'(dma_gnt), 32'h1);
    advance;
    idle_cycles(2);

    // Five CPU beats then three DMA beats from a fresh reset
    do_reset(2);
    c_cnt = 0; d_cnt = 0;
    for (int k = 0; k < 12; k++) begin
      set_cpu((k <= 5), 1, 32'h300 + 32'(k), 32'h11 + 32'(k));
      set_dma((k >= 5 && k <= 9), 1, 32'h400 + 32'(k), 32'h22 + 32'(k));
      settle;
      if (cpu_gnt && mem_en) c_cnt++;
      if (dma_gnt && mem_en) d_cnt++;
      advance;
    end
    check("f_cpu_beats", 32'(c_cnt), 32'd5);
    check("f_dma_beats", 32'(d_cnt), 32'd3);
`ifdef MEM_ARBITER_STATS_EN
    settle;
    check("f_stat_cpu", stat_cpu_beats, 32'd5);
    check("f_stat_dma", stat_dma_beats, 32'd3);
    advance;
`endif
    idle_cycles(2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, the address width of both requesters and the memory port.
REQ-002 SHALL have parameter DATA_W, default 32, the data width of both requesters and the memory port.
REQ-003 SHALL have parameter MAX_BURST, default 8, the maximum number of consecutive beats per grant; legal range 1..255.
REQ-004 SHALL have ports `clock` (in, 1, single clock, rising edge) and `reset` (in, 1, synchronous, active-high).
REQ-005 SHALL have CPU requester ports: cpu_req in 1; cpu_we in 1; cpu_addr in ADDR_W; cpu_wdata in DATA_W; cpu_gnt out 1; cpu_rvalid out 1; cpu_rdata out DATA_W.
REQ-006 SHALL have TCD/DMA requester ports: dma_req in 1; dma_we in 1; dma_addr in ADDR_W; dma_wdata in DATA_W; dma_gnt out 1; dma_rvalid out 1; dma_rdata out DATA_W.
REQ-007 SHALL have memory ports: mem_en out 1; mem_we out 1; mem_addr out ADDR_W; mem_wdata out DATA_W; mem_rdata in DATA_W, valid exactly one cycle after a read beat.

Function
REQ-008 SHALL implement FSM states IDLE, OWN_CPU and OWN_DMA, plus a 1-bit last_owner register.
REQ-009 SHALL decode grants from state only: cpu_gnt=(state==OWN_CPU), dma_gnt=(state==OWN_DMA); no combinational path from req to gnt.
REQ-010 SHALL define a beat as a cycle with X_req && X_gnt; in that cycle mem_en=1 and mem_we/addr/wdata are copied from owner X.
REQ-011 SHALL drive mem_en=0 and mem_we/addr/wdata=0 in all non-beat cycles.
REQ-012 SHALL, in IDLE with exactly one req high, move to that requester's OWN state on the next cycle (one cycle arbitration latency).
REQ-013 SHALL, in IDLE with both reqs high, grant the requester that is not last_owner (round robin).
REQ-014 SHALL keep an 8-bit beat counter that clears on entry to an OWN state and increments on every beat.
REQ-015 SHALL release ownership when the owner's req is low, or on the beat where count == MAX_BURST-1.
REQ-016 SHALL, on release, go directly to the other OWN state if the other req is high, otherwise go to IDLE; last_owner updates to the releasing requester.
REQ-017 SHALL, on a read beat, set an rvalid tag for the issuer; one cycle later it asserts that requester's rvalid for one cycle with rdata=mem_rdata.
REQ-018 SHALL hold the non-targeted rvalid at 0 and the non-targeted rdata at 0.
REQ-019 SHALL return read data for back-to-back read beats every cycle, including across an owner switch.
REQ-020 SHALL, with MAX_BURST=1, complete one beat per grant, then re-arbitrate.

Reset
REQ-021 SHALL, on reset, set state=IDLE, last_owner=DMA (so CPU wins the first tie), counter=0, and rvalid tags=0.
REQ-022 SHALL hold all outputs at 0 during reset and in the cycle after reset deasserts.
REQ-023 SHALL drop any read in flight when reset is asserted mid-operation; no rvalid is produced for it.

Configuration
REQ-024 SHALL, with MEM_ARBITER_STATS_EN defined, add outputs stat_cpu_beats and stat_dma_beats (32 bits each, wrap at 2^32, cleared by reset) that count beats per requester.
REQ-025 SHALL, with MEM_ARBITER_STATS_EN undefined, omit those ports and counters entirely.

Structure
REQ-026 SHALL place the enum arb_state_t {IDLE, OWN_CPU, OWN_DMA} and the enum owner_t {OWNER_CPU, OWNER_DMA} in shared package mem_arbiter_pkg.
REQ-027 SHALL also place the beat-counter width constant BURST_CNT_W=8 in mem_arbiter_pkg.
REQ-028 SHALL be implemented as a single module with no sub-module; the stats counters stay inline under the macro.

Verification
REQ-029 SHALL cover: after reset, cpu_req=1 alone -> cpu_gnt at cycle 1; write beat at addr 0x10 with data 0xA5 -> mem_en=1, mem_we=1, mem_addr=0x10, mem_wdata=0xA5 in the same cycle.
REQ-030 SHALL cover: both reqs rising together after reset -> CPU granted first; CPU drops req after 2 beats -> dma_gnt the next cycle with no IDLE cycle in between.
REQ-031 SHALL cover: DMA holds req for 20 read beats with MAX_BURST=8 while cpu_req=1 -> DMA gets 8 beats, CPU then gets its beats, DMA resumes.
REQ-032 SHALL cover: CPU read at 0x20 with mem_rdata=0xDEADBEEF -> cpu_rvalid=1, cpu_rdata=0xDEADBEEF exactly one cycle later, and dma_rvalid stays 0.
REQ-033 SHALL cover: reset asserted in the cycle after a DMA read beat -> dma_rvalid never asserts, and state is IDLE on the next cycle.
REQ-034 SHALL cover: with MEM_ARBITER_STATS_EN defined, 5 CPU beats and 3 DMA beats -> stat_cpu_beats=5 and stat_dma_beats=3.
